// File: rtl/litspin_pkg.sv
// Shared types and frame-buffer geometry for the LED band pipeline.
package litspin_pkg;

    localparam int unsigned FB_ADDR_W      = 10;
    localparam int unsigned FB_DATA_W      = 128;
    localparam int unsigned NB_FRAME_WORDS = 768;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA
    } fl_state_t;

endpackage

// File: rtl/frame_loader_beat_packer.sv
// Packs AVM_DW-wide read beats into frame-buffer words, first beat in the LSBs.
module beat_packer
    import litspin_pkg::*;
#(
    parameter int unsigned AVM_DW = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AVM_DW-1:0]    beat,
    input  logic                 beat_valid,
    output logic [FB_DATA_W-1:0] word,
    output logic                 word_valid
);

    localparam int unsigned PACK  = FB_DATA_W / AVM_DW;
    localparam int unsigned CNT_W = (PACK > 1) ? $clog2(PACK) : 1;

    logic [CNT_W-1:0]     cnt;
    logic [FB_DATA_W-1:0] acc;
    logic [FB_DATA_W-1:0] merged_c;
    logic                 last_c;

    // Current beat dropped into its slot of the partially built word.
    always_comb begin
        merged_c = acc;
        for (int k = 0; k < int'(PACK); k++) begin
            if (cnt == CNT_W'(k)) begin
                merged_c[k*AVM_DW +: AVM_DW] = beat;
            end
        end
        last_c = (cnt == CNT_W'(PACK - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            acc        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (start) begin
                cnt <= '0;
            end else if (beat_valid) begin
                acc <= merged_c;
                if (last_c) begin
                    cnt        <= '0;
                    word       <= merged_c;
                    word_valid <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/frame_loader.sv
// Loads one frame from SDRAM into the LED controller frame buffer per new_frame tick.
// Build option FRAME_LOADER_PINGPONG_EN alternates between frame_base and frame_base_alt.
module frame_loader
    import litspin_pkg::*;
#(
    parameter int unsigned NB_WORDS  = NB_FRAME_WORDS,
    parameter int unsigned AVM_DW    = 64,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BURST_LEN = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       new_frame,
    input  logic                       enable,
    input  logic [ADDR_W-1:0]          frame_base,
`ifdef FRAME_LOADER_PINGPONG_EN
    input  logic [ADDR_W-1:0]          frame_base_alt,
`endif
    output logic [ADDR_W-1:0]          avm_address,
    output logic                       avm_read,
    output logic [$clog2(BURST_LEN):0] avm_burstcount,
    input  logic                       avm_waitrequest,
    input  logic [AVM_DW-1:0]          avm_readdata,
    input  logic                       avm_readdatavalid,
    output logic [FB_ADDR_W-1:0]       w_addr,
    output logic [FB_DATA_W-1:0]       w_data,
    output logic                       write,
    output logic                       busy,
    output logic                       overrun
);

    localparam int unsigned PACK        = FB_DATA_W / AVM_DW;
    localparam int unsigned NB_BEATS    = NB_WORDS * PACK;
    localparam int unsigned NB_BURSTS   = NB_BEATS / BURST_LEN;
    localparam int unsigned BURST_BYTES = BURST_LEN * (AVM_DW / 8);
    localparam int unsigned BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned BURST_W     = (NB_BURSTS > 1) ? $clog2(NB_BURSTS) : 1;
    localparam int unsigned BC_W        = $clog2(BURST_LEN) + 1;

    fl_state_t            state;
    fl_state_t            state_next;
    logic [BURST_W-1:0]   burst_cnt;
    logic [BURST_W-1:0]   burst_next;
    logic [BEAT_W-1:0]    beat_cnt;
    logic [BEAT_W-1:0]    beat_next;
    logic [ADDR_W-1:0]    addr_next;
    logic                 read_next;
    logic                 busy_next;
    logic                 overrun_next;
    logic                 start_c;
    logic                 beat_valid_c;
    logic [ADDR_W-1:0]    base_sel_c;
    logic [FB_ADDR_W-1:0] word_idx;

`ifdef FRAME_LOADER_PINGPONG_EN
    logic sel;
    logic sel_next;
    assign base_sel_c = sel ? frame_base_alt : frame_base;
`else
    assign base_sel_c = frame_base;
`endif

    // Beats outside DATA belong to an aborted load and are dropped.
    assign beat_valid_c = avm_readdatavalid && (state == DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        burst_next   = burst_cnt;
        beat_next    = beat_cnt;
        addr_next    = avm_address;
        read_next    = avm_read;
        overrun_next = 1'b0;
        start_c      = 1'b0;
`ifdef FRAME_LOADER_PINGPONG_EN
        sel_next     = sel;
`endif
        case (state)
            IDLE: begin
                if (new_frame && enable) begin
                    start_c    = 1'b1;
                    state_next = REQ;
                    read_next  = 1'b1;
                    addr_next  = base_sel_c;
                    burst_next = '0;
                    beat_next  = '0;
                end
            end
            REQ: begin
                overrun_next = new_frame;
                if (!avm_waitrequest) begin
                    state_next = DATA;
                    read_next  = 1'b0;
                end
            end
            DATA: begin
                overrun_next = new_frame;
                if (avm_readdatavalid) begin
                    if (beat_cnt == BEAT_W'(BURST_LEN - 1)) begin
                        beat_next = '0;
                        if (burst_cnt == BURST_W'(NB_BURSTS - 1)) begin
                            state_next = IDLE;
`ifdef FRAME_LOADER_PINGPONG_EN
                            sel_next   = ~sel;
`endif
                        end else begin
                            state_next = REQ;
                            read_next  = 1'b1;
                            burst_next = burst_cnt + BURST_W'(1);
                            addr_next  = avm_address + ADDR_W'(BURST_BYTES);
                        end
                    end else begin
                        beat_next = beat_cnt + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                read_next  = 1'b0;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt      <= '0;
            beat_cnt       <= '0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_burstcount <= '0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            burst_cnt      <= burst_next;
            beat_cnt       <= beat_next;
            avm_address    <= addr_next;
            avm_read       <= read_next;
            avm_burstcount <= BC_W'(BURST_LEN);
            busy           <= busy_next;
            overrun        <= overrun_next;
        end
    end

`ifdef FRAME_LOADER_PINGPONG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= 1'b0;
        end else begin
            sel <= sel_next;
        end
    end
`endif

    // Word index presented with each write, restarted by every accepted frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_idx <= '0;
        end else if (start_c) begin
            word_idx <= '0;
        end else if (write) begin
            word_idx <= word_idx + FB_ADDR_W'(1);
        end
    end

    assign w_addr = word_idx;

    beat_packer #(
        .AVM_DW (AVM_DW)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .start      (start_c),
        .beat       (avm_readdata),
        .beat_valid (beat_valid_c),
        .word       (w_data),
        .word_valid (write)
    );

endmodule

// File: tb/tb_frame_loader.sv
// Randomized bench for frame_loader: Avalon slave model plus a frame-level write/busy model.
module tb_frame_loader;

    logic         clk;
    logic         rst;
    logic         new_frame;
    logic         enable;
    logic [31:0]  frame_base;
`ifdef FRAME_LOADER_PINGPONG_EN
    logic [31:0]  frame_base_alt;
`endif
    logic [31:0]  avm_address;
    logic         avm_read;
    logic [3:0]   avm_burstcount;
    logic         avm_waitrequest;
    logic [63:0]  avm_readdata;
    logic         avm_readdatavalid;
    logic [9:0]   w_addr;
    logic [127:0] w_data;
    logic         write;
    logic         busy;
    logic         overrun;

    frame_loader dut (
        .clk               (clk),
        .rst               (rst),
        .new_frame         (new_frame),
        .enable            (enable),
        .frame_base        (frame_base),
`ifdef FRAME_LOADER_PINGPONG_EN
        .frame_base_alt    (frame_base_alt),
`endif
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .w_addr            (w_addr),
        .w_data            (w_data),
        .write             (write),
        .busy              (busy),
        .overrun           (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    bit          exp_busy = 0;
    bit          frame_active = 0;
    bit          sel_m = 0;
    bit          rand_mode = 0;
    int          exp_idx = 0;
    int          exp_req = 0;
    int          frames_started = 0;
    int          frames_done = 0;
    int          writes_total = 0;
    int          overruns = 0;
    logic [31:0] exp_base = '0;
    logic [31:0] origin = '0;
    logic [31:0] first_addr_q[$];
    logic [63:0] beat_q[$];

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] word_of(input int i);
        return {64'(2 * i + 1), 64'(2 * i)};
    endfunction

    // Frame-level model: writes 0..767 in order with packed beat indices, busy/overrun rules.
    initial begin
        bit busy_before;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                chk(busy == 1'b0, "rst_busy", 128'(busy), 0);
                chk(write == 1'b0, "rst_write", 128'(write), 0);
                chk(avm_read == 1'b0, "rst_read", 128'(avm_read), 0);
                chk(overrun == 1'b0, "rst_overrun", 128'(overrun), 0);
                chk(w_addr == 10'd0, "rst_w_addr", 128'(w_addr), 0);
                chk(avm_address == 32'd0, "rst_address", 128'(avm_address), 0);
                exp_busy     = 0;
                frame_active = 0;
                exp_idx      = 0;
                sel_m        = 0;
            end else begin
                busy_before = exp_busy;
                if (write) begin
                    chk(frame_active && exp_idx < 768, "write_in_frame", 128'(w_addr), 128'(exp_idx));
                    chk(w_addr == 10'(exp_idx), "w_addr", 128'(w_addr), 128'(exp_idx));
                    chk(w_data == word_of(exp_idx), "w_data", w_data, word_of(exp_idx));
                    if (exp_idx == 0)
                        chk(w_data == 128'h0000_0000_0000_0001_0000_0000_0000_0000, "w_data_word0",
                            w_data, 128'h0000_0000_0000_0001_0000_0000_0000_0000);
                    if (exp_idx == 767)
                        chk(w_data == 128'h0000_0000_0000_05FF_0000_0000_0000_05FE, "w_data_word767",
                            w_data, 128'h0000_0000_0000_05FF_0000_0000_0000_05FE);
                    exp_idx++;
                    writes_total++;
                    if (exp_idx == 768) begin
                        exp_busy     = 0;
                        frame_active = 0;
                        frames_done++;
                        sel_m = ~sel_m;
                    end
                end
                chk(overrun == (new_frame && busy_before), "overrun", 128'(overrun),
                    128'(new_frame && busy_before));
                if (overrun) overruns++;
                if (new_frame && enable && !busy_before) begin
                    exp_busy     = 1;
                    frame_active = 1;
                    exp_idx      = 0;
                    exp_req      = 0;
`ifdef FRAME_LOADER_PINGPONG_EN
                    exp_base = sel_m ? frame_base_alt : frame_base;
`else
                    exp_base = frame_base;
`endif
                    origin = exp_base;
                    frames_started++;
                end
                chk(busy == exp_busy, "busy", 128'(busy), 128'(exp_busy));
                chk(!(avm_read && !exp_busy), "read_when_idle", 128'(avm_read), 0);
            end
        end
    end

    // Avalon slave: one burst per accepted request, beat value = beat offset from frame base.
    initial begin
        bit          pend;
        bit          stall;
        logic [31:0] pend_addr;
        pend = 0;
        stall = 0;
        pend_addr = '0;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                beat_q.delete();
                pend = 0;
                stall = 0;
                avm_readdatavalid = 1'b0;
                avm_waitrequest   = 1'b0;
            end else begin
                if (stall) begin
                    chk(avm_read == 1'b1, "stall_read_hold", 128'(avm_read), 1);
                    chk(avm_address == pend_addr, "stall_addr_hold", 128'(avm_address), 128'(pend_addr));
                end
                if (pend) begin
                    chk(pend_addr == exp_base + 32'(exp_req * 64), "req_addr", 128'(pend_addr),
                        128'(exp_base + 32'(exp_req * 64)));
                    chk(beat_q.size() == 0, "one_outstanding", 128'(beat_q.size()), 0);
                    chk(avm_burstcount == 4'd8, "burstcount", 128'(avm_burstcount), 8);
                    if (exp_req == 0) first_addr_q.push_back(pend_addr);
                    for (int i = 0; i < 8; i++)
                        beat_q.push_back(64'((pend_addr - origin) >> 3) + 64'(i));
                    exp_req++;
                end
                if (beat_q.size() > 0 && (!rand_mode || $urandom_range(0, 2) != 0)) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = beat_q.pop_front();
                end else begin
                    avm_readdatavalid = 1'b0;
                    avm_readdata      = {$urandom, $urandom};
                end
                avm_waitrequest = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
                pend      = avm_read && !avm_waitrequest;
                stall     = avm_read && avm_waitrequest;
                pend_addr = avm_address;
            end
        end
    end

    task automatic pulse_nf();
        @(negedge clk);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int c = 0;
        while (frames_done < n && c < 20000) begin
            @(negedge clk);
            c++;
        end
        chk(frames_done >= n, "frame_timeout", 128'(frames_done), 128'(n));
    endtask

    initial begin
        rst        = 1'b1;
        new_frame  = 1'b0;
        enable     = 1'b1;
        frame_base = '0;
`ifdef FRAME_LOADER_PINGPONG_EN
        frame_base_alt = '0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Zero-wait slave, single frame.
        frame_base = 32'h3000_0000;
        pulse_nf();
        wait_done(1);
        chk(writes_total == 768, "a_writes", 128'(writes_total), 768);
        chk(exp_req == 192, "a_bursts", 128'(exp_req), 192);
        chk(first_addr_q.size() > 0 && first_addr_q[0] == 32'h3000_0000, "a_first_addr",
            128'(first_addr_q.size() > 0 ? first_addr_q[0] : 32'h0), 128'h3000_0000);

        // Random stalls and gaps, plus a second tick 100 cycles into the load.
        rand_mode  = 1;
        frame_base = 32'h3000_1000;
        @(negedge clk);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        repeat (99) @(negedge clk);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        wait_done(2);
        chk(overruns == 1, "b_overruns", 128'(overruns), 1);
        chk(writes_total == 1536, "b_writes", 128'(writes_total), 1536);
        chk(frames_started == 2, "b_no_restart", 128'(frames_started), 2);
        chk(exp_req == 192, "b_bursts", 128'(exp_req), 192);

        // Tick in the first cycle back in IDLE starts a fresh load.
        rand_mode  = 0;
        frame_base = 32'h3000_2000;
        new_frame  = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        wait_done(3);
        chk(frames_started == 3, "c_accepted", 128'(frames_started), 3);
        chk(overruns == 1, "c_no_overrun", 128'(overruns), 1);

        // Disabled: tick must be ignored.
        enable = 1'b0;
        pulse_nf();
        repeat (20) @(negedge clk);
        chk(frames_started == 3, "d_ignored", 128'(frames_started), 3);
        chk(writes_total == 2304, "d_no_writes", 128'(writes_total), 2304);
        chk(busy == 1'b0, "d_busy", 128'(busy), 0);
        enable = 1'b1;

        // Reset mid-load, then restart from word 0 at the new base.
        rand_mode  = 1;
        frame_base = 32'h3000_4000;
        pulse_nf();
        begin
            int c = 0;
            while (exp_idx < 300 && c < 20000) begin
                @(negedge clk);
                c++;
            end
            chk(exp_idx >= 300, "e_reach_300", 128'(exp_idx), 300);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk(frames_done == 3, "e_abort_not_done", 128'(frames_done), 3);
        frame_base = 32'h3000_8000;
        first_addr_q.delete();
        pulse_nf();
        wait_done(4);
        chk(first_addr_q.size() > 0 && first_addr_q[0] == 32'h3000_8000, "e_restart_addr",
            128'(first_addr_q.size() > 0 ? first_addr_q[0] : 32'h0), 128'h3000_8000);

`ifdef FRAME_LOADER_PINGPONG_EN
        // Alternating bases across three frames, starting from sel=0 after reset.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rand_mode      = 0;
        frame_base     = 32'h1000_0000;
        frame_base_alt = 32'h2000_0000;
        first_addr_q.delete();
        for (int f = 0; f < 3; f++) begin
            pulse_nf();
            wait_done(5 + f);
        end
        chk(first_addr_q.size() == 3, "p_frames", 128'(first_addr_q.size()), 3);
        if (first_addr_q.size() == 3) begin
            chk(first_addr_q[0] == 32'h1000_0000, "p_addr0", 128'(first_addr_q[0]), 128'h1000_0000);
            chk(first_addr_q[1] == 32'h2000_0000, "p_addr1", 128'(first_addr_q[1]), 128'h2000_0000);
            chk(first_addr_q[2] == 32'h1000_0000, "p_addr2", 128'(first_addr_q[2]), 128'h1000_0000);
        end
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
